// File: rtl/register_file_scoreboard.sv
// Integer register file with two registered read ports, same-cycle write bypass
// and a 2-bit per-register pending counter for read-after-write hazard detection.
module register_file_scoreboard #(
  parameter  int REGISTER_WIDTH = 32,
  parameter  int REGISTER_DEPTH = 32,
  localparam int AW             = $clog2(REGISTER_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_enable,
  input  logic [AW-1:0]             wr_address,
  input  logic [REGISTER_WIDTH-1:0] wr_data,
  input  logic                      rd_enable_a,
  input  logic [AW-1:0]             rd_address_a,
  output logic [REGISTER_WIDTH-1:0] rd_data_a,
  output logic                      busy_a,
  input  logic                      rd_enable_b,
  input  logic [AW-1:0]             rd_address_b,
  output logic [REGISTER_WIDTH-1:0] rd_data_b,
  output logic                      busy_b,
  input  logic                      claim_valid,
  input  logic [AW-1:0]             claim_address,
  input  logic                      flush,
  output logic                      scoreboard_overflow
);

  logic [REGISTER_DEPTH-1:0][REGISTER_WIDTH-1:0] regs_q, regs_d;
  logic [REGISTER_DEPTH-1:0][1:0]                pend_q, pend_d;
  logic [REGISTER_DEPTH-1:0]                     inc, dec;
  logic [REGISTER_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic                      busy_a_q, busy_a_d, busy_b_q, busy_b_d;
  logic                      ovf_q, ovf_d;

  function automatic logic [REGISTER_WIDTH-1:0] rd_val(
    input logic [AW-1:0]                                 addr,
    input logic                                          we,
    input logic [AW-1:0]                                 wa,
    input logic [REGISTER_WIDTH-1:0]                     wd,
    input logic [REGISTER_DEPTH-1:0][REGISTER_WIDTH-1:0] rf
  );
    if (addr == '0)                 return '0;
    else if (we && wa == addr)      return wd;
    else                            return rf[addr];
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_enable && wr_address != '0) regs_d[wr_address] = wr_data;
    regs_d[0] = '0;
  end

  // Flush wins over claim/retire; the data write itself is unaffected.
  always_comb begin
    inc    = '0;
    dec    = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < REGISTER_DEPTH; i++) begin
      inc[i] = claim_valid && (claim_address == AW'(i)) && (i != 0);
      dec[i] = wr_enable && (wr_address == AW'(i)) && (pend_q[i] != 2'd0);
      if (i == 0)                pend_d[i] = 2'd0;
      else if (flush)            pend_d[i] = 2'd0;
      else if (inc[i] && dec[i]) pend_d[i] = pend_q[i];
      else if (inc[i]) begin
        if (pend_q[i] == 2'd3)   ovf_d     = 1'b1;
        else                     pend_d[i] = pend_q[i] + 2'd1;
      end
      else if (dec[i])           pend_d[i] = pend_q[i] - 2'd1;
    end
  end

  // Busy looks at the post-update count so same-cycle claims/retires are seen.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    busy_a_d    = busy_a_q;
    rd_data_b_d = rd_data_b_q;
    busy_b_d    = busy_b_q;
    if (rd_enable_a) begin
      rd_data_a_d = rd_val(rd_address_a, wr_enable, wr_address, wr_data, regs_q);
      busy_a_d    = (rd_address_a != '0) && (pend_d[rd_address_a] != 2'd0);
    end
    if (rd_enable_b) begin
      rd_data_b_d = rd_val(rd_address_b, wr_enable, wr_address, wr_data, regs_q);
      busy_b_d    = (rd_address_b != '0) && (pend_d[rd_address_b] != 2'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '0;
      pend_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      busy_a_q    <= 1'b0;
      busy_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pend_q      <= pend_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      busy_a_q    <= busy_a_d;
      busy_b_q    <= busy_b_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rd_data_a           = rd_data_a_q;
  assign busy_a              = busy_a_q;
  assign rd_data_b           = rd_data_b_q;
  assign busy_b              = busy_b_q;
  assign scoreboard_overflow = ovf_q;

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Architectural integer register file that terminates the register write port driven by the writeback stage. It also serves the two decode-stage source-operand reads and tracks in-flight destination registers.
- Reads are registered, one cycle, with same-cycle write bypass.
- A per-register pending counter lets decode detect read-after-write hazards and stall.
- Sits between stage 2 (decode, read/claim side) and stage 5 (writeback, write side).

## Interface
Parameters:
- REGISTER_WIDTH, 32, data width of each register
- REGISTER_DEPTH, 32, number of registers; AW = $clog2(REGISTER_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_enable  in  1  write strobe (write_in side of the writeback port: enable)
- wr_address  in  AW  write register index (address)
- wr_data  in  REGISTER_WIDTH  write data (data)
- rd_enable_a  in  1  sample source A this cycle
- rd_address_a  in  AW  source A index
- rd_data_a  out  REGISTER_WIDTH  source A value, registered
- busy_a  out  1  source A has a pending producer, registered
- rd_enable_b, rd_address_b, rd_data_b, busy_b: same as the A signals, for source B
- claim_valid  in  1  decode issues an instruction writing claim_address
- claim_address  in  AW  destination index being claimed
- flush  in  1  pipeline flush; discards all claims
- scoreboard_overflow  out  1  sticky error: claim on a saturated counter

## Operation
- Storage: REGISTER_DEPTH x REGISTER_WIDTH flops. Index 0 is hardwired zero.
- Write: at posedge, if wr_enable && wr_address != 0, then regs[wr_address] <= wr_data. Writes to x0 are dropped silently.
- Read, per port, at posedge when rd_enable is high: rd_data <= the first match below.
  - 0, if address == 0.
  - wr_data, if wr_enable && wr_address == address (bypass).
  - Otherwise regs[address].
  - When rd_enable is low, rd_data and busy hold their previous values.
- Pending counters: pend[i] is 2 bits per register, i = 1..DEPTH-1; pend[0] is constant 0.
  - inc = claim_valid && claim_address == i && i != 0.
  - dec = wr_enable && wr_address == i && pend[i] != 0.
  - Updates, in priority order:
    - flush: pend_next = 0 for all registers. flush overrides inc and dec, but the register write still occurs.
    - inc && dec: unchanged.
    - inc only: +1, saturating at 3. A claim at 3 leaves pend at 3 and sets scoreboard_overflow.
    - dec only: -1.
    - A write to a register with pend == 0 is legal: data is written and the counter is untouched.
- Busy, per port, when rd_enable is high: busy <= (address != 0) && (pend_next[address] != 0).
  - pend_next is the value after this edge's update, so a claim and a read of the same index in the same cycle returns busy = 1.
  - A write that retires the last claim in that cycle returns busy = 0, with the bypassed data.
- scoreboard_overflow is sticky and clears only on rst.

## Timing
- Reset (asynchronous assert, deassert synchronous to clk):
  - all regs = 0, all pend = 0;
  - rd_data_a = rd_data_b = 0;
  - busy_a = busy_b = 0;
  - scoreboard_overflow = 0.
- Read latency: 1 cycle. Address and enable at edge N give data and busy valid after edge N.
- Write latency: 1 cycle. A write at edge N is visible to a read sampled at edge N via bypass, and via storage from edge N+1.
- No backpressure. All inputs are sampled every edge; there is no handshake beyond the enables.
- Both read ports may name the same or any index. Both see an identical bypass.
- Reset mid-operation discards all state, including in-flight claims. Counters restart at 0.

## Test plan
- Reset, then read x5 on A and x0 on B -> rd_data_a = 0, rd_data_b = 0, busy_a = busy_b = 0, overflow = 0.
- Write x3 = 0xDEADBEEF with a read of x3 on A in the same cycle -> rd_data_a = 0xDEADBEEF (bypass). A read of x3 next cycle with no write -> 0xDEADBEEF (storage).
- Write x0 = 0x12345678, then read x0 on both ports -> both 0. Claim x0 -> busy stays 0 and pend is unchanged.
- Pending counter sequence on x7:
  - claim x7 twice -> busy = 1;
  - one write -> busy = 1;
  - second write with a simultaneous read -> busy = 0, data = the second write's value;
  - claim + write of x7 in the same cycle -> counter unchanged.
- Claim x9 four times -> pend = 3 and scoreboard_overflow = 1 (sticky). Then assert flush with a simultaneous claim of x9 -> busy for x9 = 0 next read.
- Claim x4, assert rst asynchronously mid-cycle -> all outputs 0 immediately. After release, reading x4 -> busy = 0, data = 0.
